aes_uart_block_sender: RTL

Upstream feeder for the byte-wide UART transmitter (`uart_tx`). It accepts one 128-bit AES result block through a valid/ready handshake. It splits the block into 16 bytes, most-significant byte first, and hands each byte to `uart_tx` through the transmitter's `pi_data`/`pi_flag`/`tx_busy` interface. It sits between the AES core output and `uart_tx`, so ciphertext leaves the FPGA over the serial link.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/aes_uart_block_sender.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: block sender FSM states,
// AES block width and the baud divider helper used by both sender and transmitter.
package uart_pkg;

  localparam int AES_BLK_W = 128;

  localparam int DEF_CLK_FREQ = 50000000;
  localparam int DEF_UART_BPS = 9600;
  localparam int BAUD_CNT_MAX = DEF_CLK_FREQ / DEF_UART_BPS;

  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    PULSE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } sender_state_t;

endpackage

// File: rtl/aes_uart_block_sender.sv
// Splits one accepted AES block into bytes (MSB first) and feeds them one at a
// time to uart_tx, waiting out each frame plus a full bit time before the next.
module aes_uart_block_sender
  import uart_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50000000,
  parameter int GAP_CYCLES = baud_cnt_max(CLK_FREQ, UART_BPS),
  parameter int NUM_BYTES  = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [8*NUM_BYTES-1:0] blk_data,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic [7:0]             pi_data,
  output logic                   pi_flag,
  input  logic                   tx_busy,
  output logic                   blk_done
);

  localparam int BW    = 8 * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(NUM_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  sender_state_t    state, state_next;
  logic [BW-1:0]    shift_reg, shift_next;
  logic [CNT_W-1:0] byte_cnt, byte_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [7:0]       pi_data_next;
  logic             pi_flag_next, done_next, ready_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      pi_data   <= 8'h00;
      pi_flag   <= 1'b0;
      blk_done  <= 1'b0;
      blk_ready <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      byte_cnt  <= byte_next;
      gap_cnt   <= gap_next;
      pi_data   <= pi_data_next;
      pi_flag   <= pi_flag_next;
      blk_done  <= done_next;
      blk_ready <= ready_next;
    end
  end

  // blk_ready is registered so it stays low in the IDLE cycle carrying blk_done
  // and in the cycle where a transfer is taken.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    byte_next    = byte_cnt;
    gap_next     = gap_cnt;
    pi_data_next = pi_data;
    pi_flag_next = 1'b0;
    done_next    = 1'b0;
    ready_next   = 1'b0;

    case (state)
      IDLE: begin
        if (blk_valid && blk_ready) begin
          shift_next = blk_data;
          byte_next  = '0;
          state_next = CHECK;
        end else begin
          ready_next = 1'b1;
        end
      end
      CHECK: begin
        if (!tx_busy) begin
          pi_data_next = shift_reg[BW-1 -: 8];
          pi_flag_next = 1'b1;
          state_next   = PULSE;
        end
      end
      PULSE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gap_next   = GAP_LAST;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (byte_cnt == BYTE_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            shift_next = shift_reg << 8;
            byte_next  = byte_cnt + CNT_W'(1);
            state_next = CHECK;
          end
        end else begin
          gap_next = gap_cnt - GAP_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
